// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU between the ALU decoder and writeback.
// Single-cycle and/or/add/sub/slt. sll runs on a serial shifter that moves
// one bit per cycle, so both sides use a valid/ready handshake.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   in_valid / in_ready   request handshake (in_ready only in IDLE)
//   AluCtrl               0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt, 1001 sll
//   SrcA, SrcB, Shamt     operands (SrcB is the shifted value for sll)
//   out_valid / out_ready result handshake (out_valid only in DONE)
//   AluResult, Zero       registered result and (AluResult == 0)
//   Overflow              signed add/sub overflow
//
// Optional feature macro: ALU_OVF_EN. When it is undefined, Overflow is tied
// to 0 and no overflow logic exists.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       AluCtrl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [SHW-1:0]   Shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] AluResult,
  output logic             Zero,
  output logic             Overflow
);
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1001;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] sum, diff, result_c, shreg_nxt;
  logic             accept;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_ready && in_valid;
  assign sum       = SrcA + SrcB;
  assign diff      = SrcA - SrcB;
  assign shreg_nxt = shreg << 1;

  // Undefined codes fall to the default: result 0, hence Zero=1.
  always_comb begin
    result_c = '0;
    case (AluCtrl)
      OP_AND: result_c = SrcA & SrcB;
      OP_OR:  result_c = SrcA | SrcB;
      OP_ADD: result_c = sum;
      OP_SUB: result_c = diff;
      OP_SLT: result_c = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      OP_SLL: result_c = SrcB;  // only reaches AluResult directly when Shamt==0
      default: result_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      AluResult <= '0;
      Zero      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          if (AluCtrl == OP_SLL && Shamt != '0) begin
            shreg <= SrcB;
            cnt   <= Shamt;
            state <= SHIFT;
          end else begin
            AluResult <= result_c;
            Zero      <= (result_c == '0);
            state     <= DONE;
          end
        end
        SHIFT: begin
          shreg <= shreg_nxt;
          cnt   <= cnt - 1'b1;
          // Last shift: capture the shifted value directly, not the stale shreg.
          if (cnt == SHW'(1)) begin
            AluResult <= shreg_nxt;
            Zero      <= (shreg_nxt == '0);
            state     <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_OVF_EN
  logic ovf_c;
  always_comb begin
    ovf_c = 1'b0;
    if (AluCtrl == OP_ADD)
      ovf_c = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (sum[WIDTH-1] != SrcA[WIDTH-1]);
    else if (AluCtrl == OP_SUB)
      ovf_c = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (diff[WIDTH-1] != SrcA[WIDTH-1]);
  end

  // sll takes ovf_c=0 at accept and keeps it through SHIFT.
  always_ff @(posedge clk) begin
    if (rst)         Overflow <= 1'b0;
    else if (accept) Overflow <= ovf_c;
  end
`else
  assign Overflow = 1'b0;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit.
module tb_alu_exec_unit;
  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic        in_ready, out_valid, Zero, Overflow;
  logic [3:0]  AluCtrl;
  logic [31:0] SrcA, SrcB, AluResult;
  logic [4:0]  Shamt;

  int total = 0;
  int bad   = 0;

`ifdef ALU_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  alu_exec_unit #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .AluCtrl(AluCtrl), .SrcA(SrcA), .SrcB(SrcB), .Shamt(Shamt),
    .out_valid(out_valid), .out_ready(out_ready),
    .AluResult(AluResult), .Zero(Zero), .Overflow(Overflow)
  );

  always #5 clk = ~clk;

  // Presents one op for a single cycle, then counts edges until out_valid.
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] s, output int lat);
    AluCtrl = c; SrcA = a; SrcB = b; Shamt = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    AluCtrl = 4'b0; SrcA = '0; SrcB = '0; Shamt = '0;
    repeat (2) @(posedge clk);
    #1;
    if ({in_ready, out_valid, Zero, Overflow} !== 4'b1000) begin
      bad++; $display("FAIL reset_flags got=%b exp=1000", {in_ready, out_valid, Zero, Overflow});
    end
    total++;
    if (AluResult !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", AluResult); end
    total++;
    rst = 1'b0;
  endtask

  task automatic test_add_sub_ovf();
    int lat;
    run_op(4'b0010, 32'h7FFF_FFFF, 32'h1, 5'd0, lat);
    if (lat !== 1) begin bad++; $display("FAIL add_lat got=%0d exp=1", lat); end
    total++;
    if ({AluResult, Zero, Overflow} !== {32'h8000_0000, 1'b0, OVF_ON}) begin
      bad++; $display("FAIL add_ovf got=%h/%b/%b exp=80000000/0/%b", AluResult, Zero, Overflow, OVF_ON);
    end
    total++;
    consume();
    run_op(4'b0110, 32'h8000_0000, 32'h1, 5'd0, lat);
    if ({AluResult, Zero, Overflow} !== {32'h7FFF_FFFF, 1'b0, OVF_ON}) begin
      bad++; $display("FAIL sub_ovf got=%h/%b/%b exp=7fffffff/0/%b", AluResult, Zero, Overflow, OVF_ON);
    end
    total++;
    consume();
  endtask

  task automatic test_sub_hold();
    int lat;
    run_op(4'b0110, 32'h1234, 32'h1234, 5'd0, lat);
    for (int i = 0; i < 3; i++) begin
      if ({out_valid, in_ready, AluResult, Zero, Overflow} !== {2'b10, 32'h0, 1'b1, 1'b0}) begin
        bad++; $display("FAIL sub_hold[%0d] got=%b%b/%h/%b/%b exp=10/0/1/0",
                        i, out_valid, in_ready, AluResult, Zero, Overflow);
      end
      total++;
      @(posedge clk); #1;
    end
    consume();
    if ({in_ready, out_valid} !== 2'b10) begin
      bad++; $display("FAIL sub_release got=%b exp=10", {in_ready, out_valid});
    end
    total++;
  endtask

  task automatic test_slt();
    int lat;
    run_op(4'b0111, 32'hFFFF_FFFF, 32'h1, 5'd0, lat);
    if (AluResult !== 32'h1 || Zero !== 1'b0) begin
      bad++; $display("FAIL slt_neg got=%h/%b exp=1/0", AluResult, Zero);
    end
    total++;
    consume();
    run_op(4'b0111, 32'h1, 32'hFFFF_FFFF, 5'd0, lat);
    if (AluResult !== 32'h0 || Zero !== 1'b1) begin
      bad++; $display("FAIL slt_pos got=%h/%b exp=0/1", AluResult, Zero);
    end
    total++;
    consume();
  endtask

  task automatic test_sll();
    int lat;
    run_op(4'b1001, 32'hDEAD, 32'h3, 5'd4, lat);
    if (lat !== 5 || AluResult !== 32'h30 || Overflow !== 1'b0) begin
      bad++; $display("FAIL sll4 got=lat%0d/%h/%b exp=lat5/30/0", lat, AluResult, Overflow);
    end
    total++;
    consume();
    run_op(4'b1001, 32'h0, 32'h3, 5'd0, lat);
    if (lat !== 1 || AluResult !== 32'h3) begin
      bad++; $display("FAIL sll0 got=lat%0d/%h exp=lat1/3", lat, AluResult);
    end
    total++;
    consume();
    run_op(4'b1001, 32'h0, 32'h1, 5'd31, lat);
    if (lat !== 32 || AluResult !== 32'h8000_0000 || Zero !== 1'b0) begin
      bad++; $display("FAIL sll31 got=lat%0d/%h/%b exp=lat32/80000000/0", lat, AluResult, Zero);
    end
    total++;
    consume();
  endtask

  task automatic test_rst_mid_shift();
    int seen = 0;
    AluCtrl = 4'b1001; SrcA = '0; SrcB = 32'h5; Shamt = 5'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL shift_busy got=%b exp=0", in_ready); end
    total++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    if ({in_ready, out_valid, AluResult, Zero} !== {2'b10, 32'h0, 1'b0}) begin
      bad++; $display("FAIL rst_shift got=%b%b/%h/%b exp=10/0/0", in_ready, out_valid, AluResult, Zero);
    end
    total++;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    if (seen !== 0) begin bad++; $display("FAIL rst_stale got=%0d exp=0", seen); end
    total++;
  endtask

  task automatic test_logic_undef();
    int lat;
    run_op(4'b0000, 32'hF0F0, 32'h0FF0, 5'd0, lat);
    if (AluResult !== 32'h00F0) begin bad++; $display("FAIL and got=%h exp=f0", AluResult); end
    total++;
    consume();
    run_op(4'b0001, 32'hF0F0, 32'h0FF0, 5'd0, lat);
    if (AluResult !== 32'hFFF0) begin bad++; $display("FAIL or got=%h exp=fff0", AluResult); end
    total++;
    // Pulse a new request while DONE is held: it must not disturb the result.
    AluCtrl = 4'b0010; SrcA = 32'h1; SrcB = 32'h1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    if ({out_valid, AluResult} !== {1'b1, 32'hFFF0}) begin
      bad++; $display("FAIL ignore_in got=%b/%h exp=1/fff0", out_valid, AluResult);
    end
    total++;
    consume();
    if (out_valid !== 1'b0) begin bad++; $display("FAIL ignore_ghost got=%b exp=0", out_valid); end
    total++;
    run_op(4'b0101, 32'h1234, 32'h5678, 5'd0, lat);
    if (lat !== 1 || AluResult !== 32'h0 || Zero !== 1'b1 || Overflow !== 1'b0) begin
      bad++; $display("FAIL undef got=lat%0d/%h/%b/%b exp=lat1/0/1/0", lat, AluResult, Zero, Overflow);
    end
    total++;
    consume();
  endtask

  initial begin
    test_reset();
    test_add_sub_ovf();
    test_sub_hold();
    test_slt();
    test_sll();
    test_rst_mid_shift();
    test_logic_undef();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 4-bit ALU control code from the ALU decoder and produces the registered result and zero flag.
- Handles add, sub, and, or, slt and sll.
- Single-cycle ops complete in 1 cycle. sll uses a serial 1-bit/cycle shifter, so the block has a valid/ready handshake on both sides.
- Sits between the ALU decoder and the data-memory/writeback stage.

Parameters:
- WIDTH, 32, datapath width in bits.
- SHW, 5, shift-amount width (log2 of WIDTH).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and AluCtrl are presented this cycle.
- in_ready  output  1  unit can accept an operation (IDLE only).
- AluCtrl  input  4  operation code: 0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt, 1001 sll.
- SrcA  input  WIDTH  operand A (ignored for sll).
- SrcB  input  WIDTH  operand B; the value shifted for sll.
- Shamt  input  SHW  shift amount for sll.
- out_valid  output  1  AluResult/Zero/Overflow are valid.
- out_ready  input  1  consumer takes the result this cycle.
- AluResult  output  WIDTH  registered result.
- Zero  output  1  registered (AluResult == 0), used for beq.
- Overflow  output  1  signed overflow flag (see Optional Feature).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset state: state=IDLE, in_ready=1, out_valid=0, AluResult=0, Zero=0, Overflow=0, shift register=0, counter=0.
- Reset overrides everything, including mid-shift or a held DONE result. No result is emitted for an aborted operation.
- States: IDLE, SHIFT, DONE. in_ready = (state==IDLE); out_valid = (state==DONE).
- IDLE, accept when in_valid=1 (cycle T), opcode other than sll: compute combinationally, register AluResult/Zero/Overflow, go to DONE. out_valid=1 at T+1.
- IDLE, accept sll with Shamt=0: AluResult=SrcB, go to DONE (T+1).
- IDLE, accept sll with Shamt=n>0: load shift register=SrcB and counter=n, go to SHIFT.
- SHIFT: each cycle shift register <<= 1 (zero fill) and counter decrements. When the counter goes from 1 to 0, register the result and go to DONE. out_valid=1 at T+1+n.
- DONE: AluResult/Zero/Overflow held stable while out_ready=0. When out_ready=1, go to IDLE. The next acceptance is no earlier than the following cycle; no same-cycle turnaround.
- in_valid while in_ready=0 is ignored; the upstream stage must hold its request.
- Arithmetic: add/sub are modulo 2^WIDTH. slt is a signed compare: result = {WIDTH-1 zeros, ($signed(SrcA) < $signed(SrcB))}. and/or are bitwise.
- Undefined AluCtrl codes: AluResult=0, Zero=1, Overflow=0, latency 1.
- Zero is always derived from the registered AluResult, never from the inputs.

Optional Feature:
- Macro ALU_OVF_EN.
- Defined: Overflow is registered with the result. It is 1 for add when operand signs are equal and the result sign differs. It is 1 for sub when operand signs differ and the result sign differs from SrcA. It is 0 for all other ops.
- Undefined: the Overflow port exists but is tied to 0. No overflow logic is synthesised.

Test Plan:
- add SrcA=0x7FFFFFFF, SrcB=1, accepted at T -> T+1: out_valid=1, AluResult=0x80000000, Zero=0, Overflow=1 (ALU_OVF_EN) or 0 (without).
- sub SrcA=SrcB=0x1234 -> AluResult=0, Zero=1. Hold out_ready=0 for 3 cycles -> outputs stable, in_ready=0; then out_ready=1 -> IDLE next cycle.
- slt SrcA=0xFFFFFFFF, SrcB=1 -> AluResult=1. Swap operands -> AluResult=0.
- sll SrcB=0x00000003, Shamt=4, accepted at T -> out_valid first at T+5 with AluResult=0x30. Shamt=0 -> T+1 with AluResult=3. Shamt=31, SrcB=1 -> T+32 with AluResult=0x80000000.
- Assert rst during SHIFT (Shamt=20, cycle T+7) -> next cycle IDLE, out_valid=0, AluResult=0, in_ready=1, and no stale result is produced later.
- and 0xF0F0 & 0x0FF0 -> 0x00F0. or -> 0xFFF0. AluCtrl=0101 -> AluResult=0, Zero=1. in_valid pulsed during DONE -> ignored.
